// File: rtl/matrix_row_buffer.sv
// matrix_row_buffer: three-row vertical window over a raster pixel stream.
// Two line memories hold rows r-1 and r-2; each accepted pixel emits the
// aligned column {row r-2, row r-1, row r} one cycle later.
// Optional feature macro: BORDER_REPLICATE_EN (replicate edge rows so that
// rows 0 and 1 also produce valid output columns).
module matrix_row_buffer #(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int unsigned WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sof,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eof_out
);

    localparam int unsigned DEPTH    = int'(PIC_WIDTH);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] COL_LAST = PIC_WIDTH - 11'd1;
    localparam logic [10:0] ROW_LAST = PIC_HEIGHT - 11'd1;

    logic [WIDTH-1:0] lb1_q [DEPTH];
    logic [WIDTH-1:0] lb2_q [DEPTH];

    logic [10:0]      col_q, col_d, row_q, row_d;
    logic [10:0]      cur_col, cur_row;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd1, rd2, tap1, tap2;
    logic             vld;
    logic             valid_q, valid_d, eof_q, eof_d;
    logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;

    // Position of the pixel on din (sof overrides the counters), memory
    // read taps, output tap selection and next counter values.
    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
        addr    = cur_col[AW-1:0];
        rd1     = lb1_q[addr];
        rd2     = lb2_q[addr];
`ifdef BORDER_REPLICATE_EN
        // Rows above the frame are replaced by the nearest real row.
        vld = 1'b1;
        if (cur_row == 11'd0) begin
            tap2 = din;
            tap1 = din;
        end else if (cur_row == 11'd1) begin
            tap2 = rd1;
            tap1 = rd1;
        end else begin
            tap2 = rd1;
            tap1 = rd2;
        end
`else
        vld  = (cur_row >= 11'd2);
        tap2 = rd1;
        tap1 = rd2;
`endif
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 11'd1;
            end else begin
                col_d = cur_col + 11'd1;
                row_d = cur_row;
            end
        end else if (sof) begin
            col_d = '0;
            row_d = '0;
        end
        valid_d = valid_in && vld;
        eof_d   = valid_in && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    // Counters, output strobes and output column registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            dout1_q <= '0;
            dout2_q <= '0;
            dout3_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            if (valid_in) begin
                dout3_q <= din;
                dout2_q <= tap2;
                dout1_q <= tap1;
            end
        end
    end

    // Line memories shift down one row at the current column (read-before-write).
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb2_q[addr] <= rd1;
            lb1_q[addr] <= din;
        end
    end

    assign valid_out = valid_q;
    assign eof_out   = eof_q;
    assign dout1     = dout1_q;
    assign dout2     = dout2_q;
    assign dout3     = dout3_q;

endmodule

// File: tb/tb_matrix_row_buffer.sv
// Directed bench for matrix_row_buffer with a 4x4 frame, 8-bit pixels,
// pixel value = row*16 + col.
module tb_matrix_row_buffer;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic       sof;
    logic [7:0] din;
    logic       valid_out;
    logic [7:0] dout1, dout2, dout3;
    logic       eof_out;

    int passed = 0;
    int total  = 0;

    logic [7:0] last_d, last_d1, last_d2;
    logic       last_known;

    matrix_row_buffer #(
        .PIC_WIDTH (11'd4),
        .PIC_HEIGHT(11'd4),
        .WIDTH     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .sof      (sof),
        .din      (din),
        .valid_out(valid_out),
        .dout1    (dout1),
        .dout2    (dout2),
        .dout3    (dout3),
        .eof_out  (eof_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Linear index k within a frame -> pixel value row*16+col.
    function automatic logic [7:0] px(input int k);
        return 8'(((k / 4) * 16) + (k % 4));
    endfunction

    function automatic logic exp_v(input int k);
`ifdef BORDER_REPLICATE_EN
        return 1'b1;
`else
        return (k / 4) >= 2;
`endif
    endfunction

    function automatic logic [7:0] exp_d2(input int k);
`ifdef BORDER_REPLICATE_EN
        if (k / 4 == 0) return px(k);
`endif
        return px(k) - 8'h10;
    endfunction

    function automatic logic [7:0] exp_d1(input int k);
`ifdef BORDER_REPLICATE_EN
        if (k / 4 == 0) return px(k);
        if (k / 4 == 1) return px(k) - 8'h10;
`endif
        return px(k) - 8'h20;
    endfunction

    // Present pixel k (optionally with sof) for one clock and check the result.
    task automatic push(input int k, input logic s);
        string tag;
        tag      = $sformatf("px%02h%s", px(k), s ? "_sof" : "");
        valid_in = 1'b1;
        sof      = s;
        din      = px(k);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof      = 1'b0;
        check({tag, "_valid"}, {7'd0, valid_out}, {7'd0, exp_v(k)});
        check({tag, "_eof"}, {7'd0, eof_out}, (k == 15) ? 8'd1 : 8'd0);
        check({tag, "_dout3"}, dout3, px(k));
        last_d     = px(k);
        last_known = exp_v(k);
        if (exp_v(k)) begin
            check({tag, "_dout2"}, dout2, exp_d2(k));
            check({tag, "_dout1"}, dout1, exp_d1(k));
            last_d2 = exp_d2(k);
            last_d1 = exp_d1(k);
        end
    endtask

    task automatic push_range(input int from, input int to);
        for (int k = from; k <= to; k++) push(k, 1'b0);
    endtask

    // Idle cycles: strobes low, output column held.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("gap_valid", {7'd0, valid_out}, 8'd0);
            check("gap_eof", {7'd0, eof_out}, 8'd0);
            check("gap_dout3", dout3, last_d);
            if (last_known) begin
                check("gap_dout2", dout2, last_d2);
                check("gap_dout1", dout1, last_d1);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        sof        = 1'b0;
        din        = '0;
        last_d     = '0;
        last_d1    = '0;
        last_d2    = '0;
        last_known = 1'b0;
        #2;
        check("rst_valid", {7'd0, valid_out}, 8'd0);
        check("rst_eof", {7'd0, eof_out}, 8'd0);
        check("rst_dout1", dout1, 8'd0);
        check("rst_dout2", dout2, 8'd0);
        check("rst_dout3", dout3, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame 1, continuous, sof on the first pixel.
        push(0, 1'b1);
        push_range(1, 15);

        // Frame 2 starts automatically; then every third cycle.
        push(0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            gap(2);
            push(k, 1'b0);
        end
        gap(3);

        // Frame 3: sof arriving at row 2 / col 2 restarts the frame.
        push_range(0, 9);
        push(0, 1'b1);
        push_range(1, 9);

        // Asynchronous reset mid-frame.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {7'd0, valid_out}, 8'd0);
        check("midrst_eof", {7'd0, eof_out}, 8'd0);
        check("midrst_dout1", dout1, 8'd0);
        check("midrst_dout2", dout2, 8'd0);
        check("midrst_dout3", dout3, 8'd0);
        #1;
        rst_n = 1'b1;
        last_d     = '0;
        last_known = 1'b0;
        push_range(0, 9);

        // sof without valid_in only clears the counters.
        sof = 1'b1;
        @(posedge clk);
        #1;
        sof = 1'b0;
        check("sofonly_valid", {7'd0, valid_out}, 8'd0);
        check("sofonly_dout3", dout3, last_d);
        push_range(0, 15);
        push(0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
